// File: rtl/icache_refill_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Brief   : Refill state encoding and default line geometry shared with fetch.
// Revision: 1.0
// ============================================================================
package icache_pkg;

   localparam int c_line_words = 8;   // 64-bit words per line
   localparam int c_boff_bits  = 3;   // log2(c_line_words)
   localparam int c_byte_bits  = 3;   // byte offset inside a word
   localparam int c_set_bits   = 4;   // set index width

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INVAL  = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_COMMIT = 3'd4
   } refill_state_t;

   function automatic logic [63:0] line_align(input logic [63:0] addr,
                                              input int          off_bits);
      line_align = addr & ~((64'd1 << off_bits) - 64'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill
// Brief   : Instruction-cache line refill engine: invalidate, burst read, commit.
// Revision: 1.0
// ============================================================================
module icache_refill
   import icache_pkg::*;
#(
   parameter int B = c_line_words,
   parameter int b = c_boff_bits,
   parameter int y = c_byte_bits,
   parameter int s = c_set_bits,
   parameter int t = 64 - s - b - y
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          miss_req,
   input  logic [63:0]   miss_addr,
   input  logic          lru_way,
   output logic          ar_valid,
   input  logic          ar_ready,
   output logic [63:0]   ar_addr,
   output logic [7:0]    ar_len,
   input  logic          r_valid,
   output logic          r_ready,
   input  logic [63:0]   r_data,
   input  logic          r_last,
   output logic          fill_we,
   output logic [s-1:0]  fill_set,
   output logic          fill_way,
   output logic [b-1:0]  fill_word,
   output logic [63:0]   fill_data,
   output logic          tag_we,
   output logic          tag_valid,
   output logic [t-1:0]  tag_tag,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int         c_off       = b + y;
   localparam logic [b-1:0] c_last_beat = b'(B - 1);

   refill_state_t r_state;
   logic [b-1:0]  r_beat;
   logic          w_beat_fire;
   logic          w_at_last;

   assign ar_len      = 8'(B - 1);
   assign w_beat_fire = r_ready & r_valid;
   assign w_at_last   = (r_beat == c_last_beat);

   // Data path is a pass-through so the beat lands in the array on its own
   // cycle, keeping the last fill clear of the COMMIT tag write.
   assign fill_we   = w_beat_fire;
   assign fill_word = r_beat;
   assign fill_data = r_ready ? r_data : 64'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         ar_valid  <= 1'b0;
         ar_addr   <= 64'd0;
         r_ready   <= 1'b0;
         fill_set  <= '0;
         fill_way  <= 1'b0;
         tag_we    <= 1'b0;
         tag_valid <= 1'b0;
         tag_tag   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         tag_we <= 1'b0;
         done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (miss_req) begin
                  fill_set  <= miss_addr[c_off +: s];
                  fill_way  <= lru_way;
                  tag_tag   <= miss_addr[63 -: t];
                  ar_addr   <= line_align(miss_addr, c_off);
                  r_beat    <= '0;
                  tag_we    <= 1'b1;
                  tag_valid <= 1'b0;
                  busy      <= 1'b1;
                  r_state   <= ST_INVAL;
               end
            end
            ST_INVAL: begin
               ar_valid <= 1'b1;
               r_state  <= ST_ADDR;
            end
            ST_ADDR: begin
               if (ar_ready) begin
                  ar_valid <= 1'b0;
                  r_ready  <= 1'b1;
                  r_state  <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_beat_fire) begin
                  r_beat <= r_beat + 1'b1;
                  if (r_last && w_at_last) begin
                     r_ready   <= 1'b0;
                     tag_we    <= 1'b1;
                     tag_valid <= 1'b1;
                     done      <= 1'b1;
                     r_state   <= ST_COMMIT;
                  end else if (r_last || w_at_last) begin
                     // Malformed burst: the line was invalidated up front,
                     // so abandoning it here leaves nothing stale to hit.
                     r_ready <= 1'b0;
                     err     <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_COMMIT: begin
               tag_valid <= 1'b0;
               busy      <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_refill
// Brief   : Directed self-checking bench for the icache line refill engine.
// Revision: 1.0
// ============================================================================
module tb_icache_refill;

   localparam logic [63:0] c_pat = 64'hA5A5_5A5A_0000_0000;

   logic        clk, reset;
   logic        miss_req, lru_way;
   logic [63:0] miss_addr;
   logic        ar_valid, ar_ready;
   logic [63:0] ar_addr;
   logic [7:0]  ar_len;
   logic        r_valid, r_ready, r_last;
   logic [63:0] r_data;
   logic        fill_we, fill_way;
   logic [3:0]  fill_set;
   logic [2:0]  fill_word;
   logic [63:0] fill_data;
   logic        tag_we, tag_valid;
   logic [53:0] tag_tag;
   logic        busy, done, err;

   icache_refill dut (
      .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
      .lru_way(lru_way), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .ar_addr(ar_addr), .ar_len(ar_len), .r_valid(r_valid), .r_ready(r_ready),
      .r_data(r_data), .r_last(r_last), .fill_we(fill_we), .fill_set(fill_set),
      .fill_way(fill_way), .fill_word(fill_word), .fill_data(fill_data),
      .tag_we(tag_we), .tag_valid(tag_valid), .tag_tag(tag_tag),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc = 0, miss_cyc = 0, done_cyc = 0, last_fill_cyc = 0;
   int nfill, tag_cnt, done_cnt, beat, ar_seen, ar_wait, last_at;
   bit rv_toggle;
   logic [63:0] exp_ar;
   logic        inval_tv, last_tv, last_way, obs_busy, obs_tag_we;
   logic [3:0]  last_set;
   logic [53:0] last_tag;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: observe at the falling edge, then drive the next inputs
   // just after the rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      obs_busy   = busy;
      obs_tag_we = tag_we;
      if (fill_we) begin
         check("fill_word", 64'(fill_word), 64'(nfill));
         check("fill_data", fill_data, c_pat | 64'(nfill));
         nfill++;
         last_fill_cyc = cyc;
      end
      if (fill_we && tag_we) check("fill_tag_excl", 64'(tag_we), 64'd0);
      if (ar_valid) begin
         ar_seen++;
         check("ar_addr", ar_addr, exp_ar);
         check("fill_before_ar", 64'(fill_we), 64'd0);
      end
      if (tag_we) begin
         if (tag_cnt == 0) inval_tv = tag_valid;
         tag_cnt++;
         last_tv  = tag_valid;
         last_tag = tag_tag;
         last_way = fill_way;
         last_set = fill_set;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (r_valid && r_ready) beat++;
      @(posedge clk);
      #1;
      r_valid  = rv_toggle ? ~r_valid : 1'b1;
      r_data   = c_pat | 64'(beat);
      r_last   = (beat == last_at);
      ar_ready = (ar_seen >= ar_wait);
   endtask

   task automatic start_test(input logic [63:0] addr, input int wait_ar, input int last);
      nfill = 0; tag_cnt = 0; done_cnt = 0; beat = 0; ar_seen = 0;
      inval_tv = 1'bx;
      ar_wait  = wait_ar;
      last_at  = last;
      exp_ar   = addr & ~64'h3F;
      ar_ready = (wait_ar == 0);
      r_data   = c_pat;
      r_last   = (last == 0);
   endtask

   task automatic wait_idle(input int bound);
      int  n = 0;
      bit  seen = 0;
      do begin
         tick();
         n++;
         if (obs_busy) seen = 1;
      end while (!(seen && !obs_busy) && n < bound);
      if (n >= bound) check("timeout", 64'(n), 64'(bound - 1));
   endtask

   task automatic issue(input logic [63:0] addr, input logic way);
      miss_req  = 1'b1;
      miss_addr = addr;
      lru_way   = way;
      miss_cyc  = cyc + 1;
      tick();
      miss_req  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; miss_req = 1'b0; miss_addr = 64'd0; lru_way = 1'b0;
      ar_ready = 1'b0; r_valid = 1'b0; r_data = 64'd0; r_last = 1'b0;
      rv_toggle = 1'b0;
      start_test(64'd0, 0, 7);
      tick(); tick();
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_err",   64'(err), 64'd0);
      check("rst_arv",   64'(ar_valid), 64'd0);
      check("rst_tagwe", 64'(tag_we), 64'd0);
      check("ar_len",    64'(ar_len), 64'd7);
      reset = 1'b0;
      tick();

      // 1: back-to-back handshakes; a changed request while busy is ignored
      // and the held request is only taken after an idle cycle.
      start_test(64'h1234, 0, 7);
      miss_req = 1'b1; miss_addr = 64'h1234; lru_way = 1'b1;
      miss_cyc = cyc + 1;
      tick();
      miss_addr = 64'h0000_00AB_CDEF_1FC8; lru_way = 1'b0;
      wait_idle(60);
      miss_req = 1'b0;
      check("t1_idle_gap", 64'(obs_tag_we), 64'd0);
      check("t1_latency", 64'(done_cyc - miss_cyc), 64'd11);
      check("t1_nfill",   64'(nfill), 64'd8);
      check("t1_inval",   64'(inval_tv), 64'd0);
      check("t1_tags",    64'(tag_cnt), 64'd2);
      check("t1_tv",      64'(last_tv), 64'd1);
      check("t1_tag",     64'(last_tag), 64'h4);
      check("t1_way",     64'(last_way), 64'd1);
      check("t1_set",     64'(last_set), 64'd8);
      check("t1_ar_once", 64'(ar_seen), 64'd1);

      // 2: the held request; read address withheld for five cycles
      start_test(64'h0000_00AB_CDEF_1FC8, 5, 7);
      wait_idle(80);
      check("t2_ar_cycles", 64'(ar_seen), 64'd6);
      check("t2_nfill",     64'(nfill), 64'd8);
      check("t2_done",      64'(done_cnt), 64'd1);
      check("t2_tag",       64'(last_tag), 64'h2AF37BC7);
      check("t2_way",       64'(last_way), 64'd0);
      check("t2_set",       64'(last_set), 64'hF);

      // 3: r_valid every other cycle
      rv_toggle = 1'b1;
      start_test(64'h0FFF, 0, 7);
      issue(64'h0FFF, 1'b1);
      wait_idle(80);
      rv_toggle = 1'b0;
      check("t3_nfill",  64'(nfill), 64'd8);
      check("t3_done",   64'(done_cnt), 64'd1);
      check("t3_after",  64'(done_cyc), 64'(last_fill_cyc + 1));
      check("t3_tag",    64'(last_tag), 64'h3);
      check("t3_set",    64'(last_set), 64'hF);

      // 4: early r_last on beat 3
      start_test(64'h8000_0000_0000_0100, 0, 3);
      issue(64'h8000_0000_0000_0100, 1'b0);
      wait_idle(60);
      check("t4_err",    64'(err), 64'd1);
      check("t4_nfill",  64'(nfill), 64'd4);
      check("t4_tags",   64'(tag_cnt), 64'd1);
      check("t4_inval",  64'(last_tv), 64'd0);
      check("t4_done",   64'(done_cnt), 64'd0);
      check("t4_set",    64'(last_set), 64'd4);
      check("t4_tag",    64'(last_tag), 64'h20_0000_0000_0000);

      // 5: normal refill after error, error stays sticky
      start_test(64'h40, 0, 7);
      issue(64'h40, 1'b1);
      wait_idle(60);
      check("t5_err",   64'(err), 64'd1);
      check("t5_done",  64'(done_cnt), 64'd1);
      check("t5_nfill", 64'(nfill), 64'd8);
      check("t5_set",   64'(last_set), 64'd1);

      // 6: reset while beat 4 is on the bus
      start_test(64'h2000, 0, 7);
      issue(64'h2000, 1'b1);
      for (int i = 0; i < 40 && nfill < 4; i++) tick();
      check("t6_reach", 64'(nfill), 64'd4);
      #2 reset = 1'b1;
      #1;
      check("t6_busy",  64'(busy), 64'd0);
      check("t6_err",   64'(err), 64'd0);
      check("t6_rrdy",  64'(r_ready), 64'd0);
      check("t6_fwe",   64'(fill_we), 64'd0);
      check("t6_fword", 64'(fill_word), 64'd0);
      check("t6_fdata", fill_data, 64'd0);
      check("t6_araddr", ar_addr, 64'd0);
      check("t6_tag",   64'(tag_tag), 64'd0);
      tick();
      reset = 1'b0;
      start_test(64'h3040, 0, 7);
      issue(64'h3040, 1'b0);
      wait_idle(60);
      check("t6_inval", 64'(inval_tv), 64'd0);
      check("t6_nfill", 64'(nfill), 64'd8);
      check("t6_done",  64'(done_cnt), 64'd1);
      check("t6_ntag",  64'(last_tag), 64'hC);
      check("t6_nset",  64'(last_set), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
